// File: rtl/counter_mod_n_down.sv
// Loadable mod-N down-counter / interval timer with a one-cycle terminal-count
// pulse and one-shot or periodic reload.
//
// Ports:
//   clk        in  1  system clock, rising edge
//   rst        in  1  asynchronous reset, active-low
//   en         in  1  count enable
//   load       in  1  load i_val and start running (priority over en)
//   i_periodic in  1  1 = reload on terminal count, 0 = one-shot
//   i_val      in  W  start/reload value, clamped to N-1
//   o_cnt      out W  current count
//   o_tc       out 1  registered terminal-count pulse
//   o_busy     out 1  high while running
module counter_mod_n_down #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic         i_periodic,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_cnt,
    output logic         o_tc,
    output logic         o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] MAXV = W'(N - 1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] rld_q, rld_d;
    logic         tc_q, tc_d;
    logic [W-1:0] val_clamped;

    // Compare at 32 bits so the clamp still works when N is a power of two
    // and N itself does not fit in W bits.
    assign val_clamped = (32'(i_val) >= N) ? MAXV : i_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= MAXV;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (load) begin
            // Load wins over a coinciding terminal count: no pulse.
            rld_d   = val_clamped;
            cnt_d   = val_clamped;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end else begin
                tc_d = 1'b1;
                if (i_periodic) begin
                    cnt_d = rld_q;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign o_cnt  = cnt_q;
    assign o_tc   = tc_q;
    assign o_busy = (state_q == RUN);

endmodule

// File: tb/tb_counter_mod_n_down.sv
// Self-checking bench for counter_mod_n_down: vector table on N=8,
// hand sequences on N=250, randomized run against a reference model.
module tb_counter_mod_n_down;

    logic       clk = 1'b0;
    logic       rst, en, load, per;
    logic [2:0] val8;
    logic [7:0] val250;
    logic [2:0] cnt8;
    logic [7:0] cnt250;
    logic       tc8, busy8, tc250, busy250;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    counter_mod_n_down #(.N(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .i_periodic(per), .i_val(val8),
        .o_cnt(cnt8), .o_tc(tc8), .o_busy(busy8)
    );

    counter_mod_n_down #(.N(250)) u250 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .i_periodic(per), .i_val(val250),
        .o_cnt(cnt250), .o_tc(tc250), .o_busy(busy250)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic       per;
        logic [2:0] val;
        int         cnt;
        bit         tc;
        bit         busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: remaining count, reload value, running flag.
    typedef struct {
        int cnt;
        int rld;
        bit run;
        bit tc;
    } mdl_t;

    function automatic vec_t mk(logic r, logic e, logic l, logic p,
                                logic [2:0] v, int c, bit t, bit b);
        vec_t x;
        x.rst = r; x.en = e; x.ld = l; x.per = p; x.val = v;
        x.cnt = c; x.tc = t; x.busy = b;
        return x;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit e, bit l, bit p,
                                      int v, int n);
        mdl_t r = m;
        r.tc = 1'b0;
        if (l) begin
            r.rld = (v >= n) ? n - 1 : v;
            r.cnt = r.rld;
            r.run = 1'b1;
        end else if (m.run && e) begin
            if (m.cnt > 0) begin
                r.cnt = m.cnt - 1;
            end else begin
                r.tc = 1'b1;
                if (p) r.cnt = m.rld;
                else   r.run = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mdl_t m8, m250;
        bit   seen;
        int   k;

        rst = 1'b0; en = 1'b1; load = 1'b0; per = 1'b0;
        val8 = '0; val250 = '0;

        // Reset/idle, one-shot, enable gating, load collision, zero reload.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 5, 5, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3, 3, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 2, 2, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1));

        #2;
        chk("async_reset_cnt", cnt8, 0);
        chk("async_reset_busy", busy8, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; load = vecs[i].ld;
            per = vecs[i].per; val8 = vecs[i].val;
            step();
            chk($sformatf("vec%0d_cnt", i), cnt8, vecs[i].cnt);
            chk($sformatf("vec%0d_tc", i), tc8, vecs[i].tc);
            chk($sformatf("vec%0d_busy", i), busy8, vecs[i].busy);
        end

        // Periodic with clamp on N=250: 255 -> 249, pulse every 250 edges.
        load = 1'b1; per = 1'b1; en = 1'b1; val250 = 8'd255;
        step();
        load = 1'b0;
        chk("clamp_cnt", cnt250, 249);
        chk("clamp_busy", busy250, 1);
        for (int p = 0; p < 2; p++) begin
            seen = 1'b0;
            k = 0;
            while (!seen && k < 300) begin
                step();
                k++;
                if (tc250) seen = 1'b1;
            end
            chk($sformatf("period%0d_len", p), k, 250);
            chk($sformatf("period%0d_reload", p), cnt250, 249);
        end

        // Asynchronous reset mid-count at 100.
        load = 1'b1; val250 = 8'd100; en = 1'b0;
        step();
        load = 1'b0;
        chk("pre_rst_cnt", cnt250, 100);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt250, 0);
        chk("mid_rst_busy", busy250, 0);
        #3 rst = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_cnt", cnt250, 0);
            chk("post_rst_busy", busy250, 0);
        end

        // Randomized run against the model on both instances.
        rst = 1'b0;
        #2 rst = 1'b1;
        m8 = '{cnt: 0, rld: 7, run: 0, tc: 0};
        m250 = '{cnt: 0, rld: 249, run: 0, tc: 0};
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) per = ~per;
            val8 = 3'($urandom_range(0, 7));
            val250 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                                 : 8'($urandom_range(0, 12));
            m8 = mdl_step(m8, en, load, per, int'(val8), 8);
            m250 = mdl_step(m250, en, load, per, int'(val250), 250);
            step();
            chk("rnd8_cnt", cnt8, m8.cnt);
            chk("rnd8_tc", tc8, m8.tc);
            chk("rnd8_busy", busy8, m8.run);
            chk("rnd250_cnt", cnt250, m250.cnt);
            chk("rnd250_tc", tc250, m250.tc);
            chk("rnd250_busy", busy250, m250.run);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/counter_mod_n_down.md
Name: counter_mod_n_down

Overview:
- Loadable mod-N down-counter / interval timer. Complements the existing up-counting mod-N counter.
- Counts from a programmed value down to 0, then emits a one-cycle terminal-count pulse.
- Either stops (one-shot) or reloads and continues (periodic).
- Used as a programmable tick and timeout generator next to the up-counters in the lab designs.

Parameters:
- N, 8, modulus: the largest loadable value is N-1. Legal range N >= 2.
- W, (N>1 ? $clog2(N) : 1), counter width. Derived only; not overridden by instantiators.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately
- en  input  1  count enable; decrement only when high
- load  input  1  load i_val and start running; has priority over en
- i_periodic  input  1  1 = reload on terminal count; 0 = one-shot. Sampled every cycle.
- i_val  input  W  start/reload value; values >= N are clamped to N-1
- o_cnt  output  W  current count
- o_tc  output  1  terminal-count pulse, one cycle, registered
- o_busy  output  1  1 while the state is RUN

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, o_cnt=0, o_tc=0, o_busy=0, internal reload register=N-1.
  - Takes effect mid-count with no clock edge needed.
  - Counting resumes only after a load following rst returning to 1.
- States are IDLE and RUN. o_busy is 1 exactly when state=RUN, and is a registered output.
- Load (rising edge with load=1, any state):
  - Clamped value v = (i_val >= N) ? N-1 : i_val.
  - reload register <= v, o_cnt <= v, state <= RUN, o_tc <= 0.
  - en is ignored on that edge.
- RUN, en=1, load=0:
  - If o_cnt > 0: o_cnt <= o_cnt-1, o_tc <= 0.
  - If o_cnt == 0: o_tc <= 1 for exactly one cycle, then:
    - i_periodic=1: o_cnt <= reload register, stay RUN.
    - i_periodic=0: o_cnt stays 0, state <= IDLE.
- RUN, en=0, load=0: o_cnt and state hold, o_tc <= 0.
- IDLE, load=0: o_cnt holds, en ignored, o_tc <= 0.
- Period: in periodic mode with en held high and reload value v, o_tc pulses every v+1 cycles.
  - v=0 gives o_tc high on every enabled cycle.
- Latency:
  - o_cnt shows the loaded value on the first edge after load.
  - The first o_tc appears v+1 enabled edges after the load edge.
- Load on the same edge as terminal count: load wins. No o_tc pulse; the counter restarts from the new v.
- Arithmetic: unsigned; the decrement never underflows because 0 is handled explicitly.
- No X propagation: every register is reset.

Test Plan:
1. Reset and idle. N=8: hold rst=0 for 4 cycles with en=1 and load=0, then release.
   - Required: o_cnt=0, o_tc=0, o_busy=0 throughout; en alone never starts counting.
2. One-shot. N=8: load i_val=5 with i_periodic=0, then en=1.
   - Required: o_cnt 5,4,3,2,1,0.
   - o_tc=1 for one cycle, on the 6th enabled edge after the load edge.
   - o_busy then drops to 0 and o_cnt stays 0.
3. Periodic with clamp. N=250: load i_val=255 with i_periodic=1, en=1.
   - Required: o_cnt loads 249.
   - o_tc pulses every 250 cycles; after each pulse o_cnt returns to 249.
4. Enable gating. N=8, periodic, loaded with 3: toggle en 1,0,0,1,1,1.
   - Required: o_cnt 3,2,2,2,1,0; no o_tc while en=0.
   - o_tc fires on the next enabled edge, then o_cnt reloads to 3.
5. Asynchronous reset mid-count. N=250, count at 100: pulse rst=0 for 4 time units between clock edges.
   - Required: o_cnt=0 and o_busy=0 immediately, without waiting for a clock edge.
   - After release there is no counting until a load.
6. Load collision and zero value. N=8: while o_cnt=0 in RUN, assert load with i_val=2.
   - Required: no o_tc on that edge; o_cnt=2.
   - Then load i_val=0 with periodic=1 and en=1: o_tc must stay high on every cycle.
